// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: opcodes and FSM states.
package hilo_muldiv_unit_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_muldiv_unit_iter_core.sv
// Radix-2 iterative engine: shift-add multiply or restoring shift-subtract divide on
// unsigned magnitudes. Result is {acc, sr}: product {hi,lo}, or {remainder, quotient}.
module hilo_muldiv_unit_iter_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic         mode_div,
  input  logic [W-1:0] a_mag,
  input  logic [W-1:0] b_mag,
  output logic [W-1:0] acc,
  output logic [W-1:0] sr
);

  logic [W-1:0] opnd;
  logic         mode_div_r;
  logic [W:0]   sum;
  logic [W:0]   shifted;
  logic [W:0]   trial;

  always_comb begin
    sum     = {1'b0, acc} + (sr[0] ? {1'b0, opnd} : '0);
    shifted = {acc, sr[W-1]};
    trial   = shifted - {1'b0, opnd};
  end

  // The remainder always fits in W bits, so trial[W] alone tells whether the subtract fits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      sr         <= '0;
      opnd       <= '0;
      mode_div_r <= 1'b0;
    end else if (load) begin
      acc        <= '0;
      sr         <= a_mag;
      opnd       <= b_mag;
      mode_div_r <= mode_div;
    end else if (step) begin
      if (mode_div_r) begin
        if (!trial[W]) begin
          acc <= trial[W-1:0];
          sr  <= {sr[W-2:0], 1'b1};
        end else begin
          acc <= shifted[W-1:0];
          sr  <= {sr[W-2:0], 1'b0};
        end
      end else begin
        acc <= sum[W:1];
        sr  <= {sum[0], sr[W-1:1]};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with an iterative signed/unsigned multiply/divide unit behind a
// start/ready/done handshake; MTHI/MTLO write HI/LO directly in one cycle.
//
//   state  | meaning
//   S_IDLE | ready; accepts MULT*/DIV*, MTHI/MTLO, reserved no-ops
//   S_CALC | one radix-2 step per cycle, counter W-1 down to 0
//   S_FIX  | apply result signs, write {hi,lo} on exit
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         abort,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic         div0,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  state_t         state;
  logic [CNT_W-1:0] cnt;
  logic           mode_div;
  logic           neg_q;
  logic           neg_r;
  logic           zero_div;

  logic           accept;
  logic           iter_op;
  logic           signed_op;
  logic           div_op;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W-1:0]   core_acc;
  logic [W-1:0]   core_sr;
  logic [2*W-1:0] prod_mag;
  logic [2*W-1:0] prod;
  logic [W-1:0]   res_hi;
  logic [W-1:0]   res_lo;

  assign ready  = (state == S_IDLE);
  assign busy   = !ready;
  assign accept = start && ready && !abort;

  always_comb begin
    iter_op   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    div_op    = (op == OP_DIV) || (op == OP_DIVU);
    a_neg     = signed_op && a[W-1];
    b_neg     = signed_op && b[W-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  hilo_muldiv_unit_iter_core #(.W(W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && iter_op),
    .step     ((state == S_CALC) && !abort),
    .mode_div (div_op),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc      (core_acc),
    .sr       (core_sr)
  );

  // Divide by zero: the engine already yields remainder |a|, so the sign fix restores a;
  // only the quotient needs forcing to all ones.
  always_comb begin
    prod_mag = {core_acc, core_sr};
    prod     = neg_q ? -prod_mag : prod_mag;
    res_hi   = prod[2*W-1:W];
    res_lo   = prod[W-1:0];
    if (mode_div) begin
      res_hi = neg_r ? -core_acc : core_acc;
      res_lo = zero_div ? '1 : (neg_q ? -core_sr : core_sr);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mode_div <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_div <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div0     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (iter_op) begin
              state    <= S_CALC;
              cnt      <= CNT_W'(W - 1);
              mode_div <= div_op;
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              zero_div <= div_op && (b == '0);
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        S_CALC: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!abort) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
            div0 <= mode_div && zero_div;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit at W=32 with hand-computed expected results.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         abort;
  logic         ready;
  logic         busy;
  logic         done;
  logic         div0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad   = 0;
  int n;
  int nd;

  hilo_muldiv_unit #(.W(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .abort (abort),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_ready", 64'(ready), 64'h1);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_div0", 64'(div0), 64'h0);
    rst = 1'b1;
    @(negedge clk);

    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_busy", 64'(busy), 64'h1);
    chk("multu_ready", 64'(ready), 64'h0);
    wait_done(n);
    chk("multu_latency", 64'(n), 64'd33);
    chk("multu_hi", 64'(hi), 64'hFFFFFFFE);
    chk("multu_lo", 64'(lo), 64'h00000001);
    chk("multu_div0", 64'(div0), 64'h0);
    chk("multu_ready_done", 64'(ready), 64'h1);

    issue(OP_MULT, 32'hFFFFFFFD, 32'h00000007);
    chk("b2b_accepted", 64'(busy), 64'h1);
    wait_done(n);
    chk("mult_latency", 64'(n), 64'd33);
    chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo), 64'hFFFFFFEB);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'h0);

    issue(OP_DIV, 32'hFFFFFFF9, 32'h00000002);
    wait_done(n);
    chk("div_lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_hi", 64'(hi), 64'hFFFFFFFF);
    @(negedge clk);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    chk("ovf_lo", 64'(lo), 64'h80000000);
    chk("ovf_hi", 64'(hi), 64'h0);
    chk("ovf_div0", 64'(div0), 64'h0);

    @(negedge clk);
    issue(OP_DIVU, 32'h5, 32'h0);
    wait_done(n);
    chk("div0_lo", 64'(lo), 64'hFFFFFFFF);
    chk("div0_hi", 64'(hi), 64'h5);
    chk("div0_flag", 64'(div0), 64'h1);
    @(negedge clk);
    issue(OP_MULTU, 32'h2, 32'h3);
    wait_done(n);
    chk("mul23_lo", 64'(lo), 64'h6);
    chk("mul23_hi", 64'(hi), 64'h0);
    chk("mul23_div0", 64'(div0), 64'h0);

    @(negedge clk);
    issue(OP_MTHI, 32'h1234, 32'h0);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'h0);
    chk("mthi_done", 64'(done), 64'h0);
    issue(OP_MTLO, 32'hABCD, 32'h0);
    chk("mtlo_lo", 64'(lo), 64'hABCD);
    issue(OP_MULT, 32'h5, 32'h6);
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'h7; b = 32'h7;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_start_busy", 64'(busy), 64'h1);
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_ready", 64'(ready), 64'h1);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'h0);
    chk("abort_hi", 64'(hi), 64'h1234);
    chk("abort_lo", 64'(lo), 64'hABCD);

    abort = 1'b1;
    issue(OP_MTHI, 32'h9, 32'h0);
    abort = 1'b0;
    chk("idle_abort_hi", 64'(hi), 64'h1234);

    issue(3'b110, 32'h77, 32'h77);
    chk("rsvd_busy", 64'(busy), 64'h0);
    chk("rsvd_hi", 64'(hi), 64'h1234);
    chk("rsvd_lo", 64'(lo), 64'hABCD);

    issue(OP_DIV, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_hi", 64'(hi), 64'h0);
    chk("midrst_lo", 64'(lo), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_ready", 64'(ready), 64'h1);
    chk("midrst_done", 64'(done), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(OP_DIVU, 32'd9, 32'd4);
    wait_done(n);
    chk("divu_latency", 64'(n), 64'd33);
    chk("divu_lo", 64'(lo), 64'h2);
    chk("divu_hi", 64'(hi), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
